// File: rtl/ads8528_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ads8528_pkg
// Description : Shared types and constants for the ADS8528 interface controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ads8528_pkg;

    typedef logic [2:0] ctrl_state_t;

    localparam ctrl_state_t ST_CFG_SETUP = 3'd0;
    localparam ctrl_state_t ST_CFG_WR    = 3'd1;
    localparam ctrl_state_t ST_IDLE      = 3'd2;
    localparam ctrl_state_t ST_CONV      = 3'd3;
    localparam ctrl_state_t ST_WAIT_BH   = 3'd4;
    localparam ctrl_state_t ST_WAIT_BL   = 3'd5;
    localparam ctrl_state_t ST_READ      = 3'd6;

    typedef enum logic [2:0] {
        CH_A0, CH_A1, CH_B0, CH_B1, CH_C0, CH_C1, CH_D0, CH_D1
    } ch_idx_t;

    localparam int CLKSEL_BIT = 29;

    function automatic logic [31:0] with_clksel(input logic [31:0] word, input logic clksel);
        logic [31:0] w;
        w             = word;
        w[CLKSEL_BIT] = clksel;
        return w;
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // CLKSEL cleared: the ADC runs on its internal conversion clock.
    localparam logic [31:0] DEFAULT_CONFIG_WORD = with_clksel(32'h0000_03FF, 1'b0);

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for asynchronous level inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/ads8528_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ads8528_ctrl
// Description : ADS8528 parallel-bus controller: config write, CONVST, BUSY
//               tracking and eight-word readout per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module ads8528_ctrl
    import ads8528_pkg::*;
#(
    parameter logic [31:0] CONFIG_WORD  = DEFAULT_CONFIG_WORD,
    parameter int          T_WR_LO      = 3,
    parameter int          T_WR_HI      = 3,
    parameter int          T_CONV_HI    = 4,
    parameter int          T_RD_LO      = 4,
    parameter int          T_RD_HI      = 3,
    parameter int          BUSY_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        busy,
    input  logic [15:0] db_in,
    output logic [15:0] db_out,
    output logic        db_oe,
    output logic        cs_n,
    output logic        wr_n,
    output logic        rd_n,
    output logic        convst_a,
    output logic        convst_b,
    output logic        convst_c,
    output logic        convst_d,
    output logic        ready,
    output logic [15:0] sample_data,
    output logic [2:0]  sample_ch,
    output logic        sample_valid,
    output logic        frame_done,
    output logic        timeout_err
);

    localparam int c_T_MAX = max_of(max_of(T_WR_LO, T_WR_HI),
                                    max_of(max_of(T_CONV_HI, T_RD_LO), T_RD_HI));
    localparam int c_TMR_W = $clog2(c_T_MAX) + 1;
    localparam int c_TO_W  = $clog2(BUSY_TIMEOUT + 1);

    // Timers hold "cycles remaining minus one"; a phase ends on the zero cycle.
    localparam logic [c_TMR_W-1:0] c_WR_LO_LD   = c_TMR_W'(T_WR_LO - 1);
    localparam logic [c_TMR_W-1:0] c_WR_HI_LD   = c_TMR_W'(T_WR_HI - 1);
    localparam logic [c_TMR_W-1:0] c_CONV_LD    = c_TMR_W'(T_CONV_HI - 1);
    localparam logic [c_TMR_W-1:0] c_RD_LO_LD   = c_TMR_W'(T_RD_LO - 1);
    localparam logic [c_TMR_W-1:0] c_RD_HI_LD   = c_TMR_W'(T_RD_HI - 1);
    localparam logic [c_TO_W-1:0]  c_TO_LD      = c_TO_W'(BUSY_TIMEOUT - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE    = c_TMR_W'(1);
    localparam logic [c_TO_W-1:0]  c_TO_ONE     = c_TO_W'(1);

    ctrl_state_t         r_state;
    logic                r_phase_hi;
    logic                r_word;
    logic [c_TMR_W-1:0]  r_tmr;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic [2:0]          r_rd_idx;
    logic [15:0]         r_db_out;
    logic                r_db_oe;
    logic                r_cs_n;
    logic                r_wr_n;
    logic                r_rd_n;
    logic                r_convst;
    logic                r_ready;
    logic [15:0]         r_sample_data;
    logic [2:0]          r_sample_ch;
    logic                r_sample_valid;
    logic                r_frame_done;
    logic                r_timeout_err;
    logic                w_busy_s;

    sync_2ff #(.WIDTH(1)) u_busy_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (busy),
        .q     (w_busy_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_CFG_SETUP;
            r_phase_hi     <= 1'b0;
            r_word         <= 1'b0;
            r_tmr          <= '0;
            r_to_cnt       <= '0;
            r_rd_idx       <= '0;
            r_db_out       <= '0;
            r_db_oe        <= 1'b0;
            r_cs_n         <= 1'b1;
            r_wr_n         <= 1'b1;
            r_rd_n         <= 1'b1;
            r_convst       <= 1'b0;
            r_ready        <= 1'b0;
            r_sample_data  <= '0;
            r_sample_ch    <= '0;
            r_sample_valid <= 1'b0;
            r_frame_done   <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            r_frame_done   <= 1'b0;
            r_timeout_err  <= 1'b0;
            case (r_state)
                ST_CFG_SETUP: begin
                    r_cs_n     <= 1'b0;
                    r_db_oe    <= 1'b1;
                    r_db_out   <= r_word ? CONFIG_WORD[15:0] : CONFIG_WORD[31:16];
                    r_wr_n     <= 1'b0;
                    r_phase_hi <= 1'b0;
                    r_tmr      <= c_WR_LO_LD;
                    r_state    <= ST_CFG_WR;
                end
                ST_CFG_WR: begin
                    if (r_tmr != '0) begin
                        r_tmr <= r_tmr - c_TMR_ONE;
                    end else if (!r_phase_hi) begin
                        r_wr_n     <= 1'b1;
                        r_phase_hi <= 1'b1;
                        r_tmr      <= c_WR_HI_LD;
                    end else if (!r_word) begin
                        r_word   <= 1'b1;
                        r_db_out <= CONFIG_WORD[15:0];
                        r_state  <= ST_CFG_SETUP;
                    end else begin
                        r_cs_n   <= 1'b1;
                        r_db_oe  <= 1'b0;
                        r_db_out <= '0;
                        r_ready  <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (start) begin
                        r_ready  <= 1'b0;
                        r_convst <= 1'b1;
                        r_tmr    <= c_CONV_LD;
                        r_state  <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (r_tmr != '0) begin
                        r_tmr <= r_tmr - c_TMR_ONE;
                    end else begin
                        r_convst <= 1'b0;
                        r_to_cnt <= c_TO_LD;
                        r_state  <= ST_WAIT_BH;
                    end
                end
                ST_WAIT_BH, ST_WAIT_BL: begin
                    if ((r_state == ST_WAIT_BH) && w_busy_s) begin
                        r_to_cnt <= c_TO_LD;
                        r_state  <= ST_WAIT_BL;
                    end else if ((r_state == ST_WAIT_BL) && !w_busy_s) begin
                        r_cs_n     <= 1'b0;
                        r_rd_n     <= 1'b0;
                        r_phase_hi <= 1'b0;
                        r_rd_idx   <= '0;
                        r_tmr      <= c_RD_LO_LD;
                        r_state    <= ST_READ;
                    end else if (r_to_cnt == '0) begin
                        // BUSY never arrived: abandon the frame without emitting samples.
                        r_timeout_err <= 1'b1;
                        r_convst      <= 1'b0;
                        r_cs_n        <= 1'b1;
                        r_rd_n        <= 1'b1;
                        r_ready       <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt - c_TO_ONE;
                    end
                end
                ST_READ: begin
                    if (r_tmr != '0) begin
                        r_tmr <= r_tmr - c_TMR_ONE;
                    end else if (!r_phase_hi) begin
                        r_sample_data  <= db_in;
                        r_sample_ch    <= r_rd_idx;
                        r_sample_valid <= 1'b1;
                        r_frame_done   <= (r_rd_idx == CH_D1);
                        r_rd_n         <= 1'b1;
                        r_phase_hi     <= 1'b1;
                        r_tmr          <= c_RD_HI_LD;
                    end else if (r_rd_idx == CH_D1) begin
                        r_cs_n  <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_rd_idx   <= r_rd_idx + 3'd1;
                        r_rd_n     <= 1'b0;
                        r_phase_hi <= 1'b0;
                        r_tmr      <= c_RD_LO_LD;
                    end
                end
                default: begin
                    r_convst <= 1'b0;
                    r_cs_n   <= 1'b1;
                    r_wr_n   <= 1'b1;
                    r_rd_n   <= 1'b1;
                    r_db_oe  <= 1'b0;
                    r_ready  <= 1'b1;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign db_out       = r_db_out;
    assign db_oe        = r_db_oe;
    assign cs_n         = r_cs_n;
    assign wr_n         = r_wr_n;
    assign rd_n         = r_rd_n;
    assign convst_a     = r_convst;
    assign convst_b     = r_convst;
    assign convst_c     = r_convst;
    assign convst_d     = r_convst;
    assign ready        = r_ready;
    assign sample_data  = r_sample_data;
    assign sample_ch    = r_sample_ch;
    assign sample_valid = r_sample_valid;
    assign frame_done   = r_frame_done;
    assign timeout_err  = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_ads8528_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ads8528_ctrl
// Description : Self-checking bench with a behavioural ADS8528 and a sample scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ads8528_ctrl;

    typedef struct {
        logic [2:0]  ch;
        logic [15:0] data;
    } smp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy = 1'b0;
    logic [15:0] db_in;
    logic [15:0] db_out;
    logic        db_oe, cs_n, wr_n, rd_n;
    logic        convst_a, convst_b, convst_c, convst_d;
    logic        ready, sample_valid, frame_done, timeout_err;
    logic [15:0] sample_data;
    logic [2:0]  sample_ch;

    logic [31:0] cfg_word = 32'h0000_03FF;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_valid = 0;
    int          n_fd = 0;
    int          n_conv = 0;
    int          n_excl_viol = 0;
    int          n_frames_exp = 0;
    int          busy_mode = 0;
    int          bh_dly = 2;
    int          bl_dly = 40;
    logic [15:0] adc_data [8];
    int          adc_idx = 0;
    logic        prev_rd = 1'b1;
    logic        prev_cv = 1'b0;
    smp_t        exp_q [$];

    always #5 clk = ~clk;

    ads8528_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .busy         (busy),
        .db_in        (db_in),
        .db_out       (db_out),
        .db_oe        (db_oe),
        .cs_n         (cs_n),
        .wr_n         (wr_n),
        .rd_n         (rd_n),
        .convst_a     (convst_a),
        .convst_b     (convst_b),
        .convst_c     (convst_c),
        .convst_d     (convst_d),
        .ready        (ready),
        .sample_data  (sample_data),
        .sample_ch    (sample_ch),
        .sample_valid (sample_valid),
        .frame_done   (frame_done),
        .timeout_err  (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // ADC output register: new conversion results on CONVST, next channel after each RD_N.
    assign db_in = adc_data[adc_idx[2:0]];

    always @(negedge clk) begin
        if (convst_a && !prev_cv) begin
            adc_idx = 0;
            for (int i = 0; i < 8; i++) adc_data[i] = 16'($urandom);
        end else if (rd_n && !prev_rd) begin
            adc_idx = adc_idx + 1;
        end
        prev_cv = convst_a;
        prev_rd = rd_n;
    end

    always @(posedge convst_a) begin
        n_conv++;
        if (busy_mode == 0) begin
            repeat (bh_dly) @(posedge clk);
            #2 busy = 1'b1;
            repeat (bl_dly) @(posedge clk);
            #2 busy = 1'b0;
            for (int i = 0; i < 8; i++) begin
                smp_t s;
                s.ch   = i[2:0];
                s.data = adc_data[i];
                exp_q.push_back(s);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (!wr_n && !rd_n) n_excl_viol++;
            if (db_oe && !rd_n) n_excl_viol++;
        end
        if (frame_done) n_fd++;
        if (sample_valid) begin
            n_valid++;
            chk("sample_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                smp_t s;
                s = exp_q.pop_front();
                chk("sample_ch", 32'(sample_ch), 32'(s.ch));
                chk("sample_data", 32'(sample_data), 32'(s.data));
                chk("frame_done_with_d1", 32'(frame_done), 32'(s.ch == 3'd7));
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_strobes"}, 32'({cs_n, wr_n, rd_n, db_oe}), 32'b1110);
        chk({tag, "_convst"}, 32'({convst_a, convst_b, convst_c, convst_d}), 32'd0);
        chk({tag, "_status"}, 32'({ready, sample_valid, frame_done, timeout_err}), 32'd0);
        chk({tag, "_db_out"}, 32'(db_out), 32'd0);
        chk({tag, "_sample"}, 32'({sample_ch, sample_data}), 32'd0);
    endtask

    task automatic run_config(input string tag);
        int          nwr, rdy_cyc, cs_bad, oe_bad, cur_lo;
        int          lo_len [2];
        logic [15:0] words [2];
        logic        pw;
        logic [15:0] pdb;
        nwr = 0; rdy_cyc = -1; cs_bad = 0; oe_bad = 0; cur_lo = 0;
        lo_len[0] = 0; lo_len[1] = 0; words[0] = 16'hDEAD; words[1] = 16'hDEAD;
        pw = 1'b1; pdb = 16'h0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (!wr_n) begin
                cur_lo++;
                if (cs_n) cs_bad++;
                if (!db_oe) oe_bad++;
            end else if (!pw) begin
                if (nwr < 2) begin
                    words[nwr]  = pdb;
                    lo_len[nwr] = cur_lo;
                end
                nwr++;
                cur_lo = 0;
            end
            if (ready && rdy_cyc < 0) rdy_cyc = cyc;
            if (rdy_cyc >= 0 && db_oe) oe_bad++;
            pw  = wr_n;
            pdb = db_out;
        end
        chk({tag, "_wr_pulses"}, 32'(nwr), 32'd2);
        chk({tag, "_word0"}, 32'(words[0]), 32'(cfg_word[31:16]));
        chk({tag, "_word1"}, 32'(words[1]), 32'(cfg_word[15:0]));
        chk({tag, "_wr_lo0"}, 32'(lo_len[0]), 32'd3);
        chk({tag, "_wr_lo1"}, 32'(lo_len[1]), 32'd3);
        chk({tag, "_cs_low_in_wr"}, 32'(cs_bad), 32'd0);
        chk({tag, "_db_oe"}, 32'(oe_bad), 32'd0);
        chk({tag, "_ready_cycle"}, 32'(rdy_cyc), 32'd14);
        chk({tag, "_idle_cs_n"}, 32'(cs_n), 32'd1);
    endtask

    task automatic wait_ready(input string tag);
        int c;
        c = 0;
        while (!ready && c < 2000) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_ready"}, 32'(ready), 32'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_frame(input bit poke_start);
        int c, first_rd, v0, conv0;
        v0 = n_valid;
        conv0 = n_conv;
        wait_ready("frame_pre");
        pulse_start();
        chk("convst_after_start", 32'({convst_a, convst_b, convst_c, convst_d}), 32'hF);
        chk("ready_low_in_conv", 32'(ready), 32'd0);
        c = 0;
        while (busy !== 1'b1 && c < 200) begin @(negedge clk); c++; end
        chk("busy_rise_seen", 32'(busy), 32'd1);
        c = 0;
        while (busy !== 1'b0 && c < 400) begin @(negedge clk); c++; end
        chk("busy_fall_seen", 32'(busy), 32'd0);
        first_rd = -1;
        c = 0;
        while (!ready && c < 200) begin
            @(negedge clk);
            c++;
            if (poke_start) begin
                if (c == 20) start = 1'b1;
                else if (c == 21) start = 1'b0;
            end
            if (!rd_n && first_rd < 0) first_rd = c;
        end
        chk("rd_latency", 32'(first_rd), 32'd3);
        chk("frame_length", 32'(c), 32'd59);
        chk("frame_samples", 32'(n_valid - v0), 32'd8);
        n_frames_exp++;
        if (poke_start) begin
            repeat (10) @(negedge clk);
            chk("start_in_read_ignored", 32'(n_conv - conv0), 32'd1);
            chk("idle_after_frame", 32'(ready), 32'd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got hang, want finish");
        $fatal(1);
    end

    initial begin
        int c, v0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        run_config("cfg1");

        do_frame(1'b0);
        do_frame(1'b1);

        // BUSY never rises: expect a timeout 1024 cycles into the wait.
        busy_mode = 1;
        v0 = n_valid;
        wait_ready("to_pre");
        pulse_start();
        c = 0;
        while (convst_a && c < 50) begin @(negedge clk); c++; end
        chk("to_convst_fell", 32'(convst_a), 32'd0);
        c = 0;
        while (!timeout_err && c < 1100) begin @(negedge clk); c++; end
        chk("timeout_cycles", 32'(c), 32'd1024);
        @(negedge clk);
        chk("timeout_pulse_width", 32'(timeout_err), 32'd0);
        chk("timeout_ready", 32'(ready), 32'd1);
        chk("timeout_no_samples", 32'(n_valid - v0), 32'd0);
        busy_mode = 0;

        // Reset asserted while read index 4 is on the bus.
        bh_dly = 2; bl_dly = 40;
        wait_ready("abort_pre");
        pulse_start();
        c = 0;
        while (!(adc_idx == 4 && !rd_n) && c < 300) begin @(negedge clk); c++; end
        chk("abort_point", 32'(adc_idx == 4 && !rd_n), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("abort");
        exp_q.delete();
        v0 = n_valid;
        repeat (3) @(negedge clk);
        run_config("cfg2");
        chk("abort_no_samples", 32'(n_valid - v0), 32'd0);

        for (int f = 0; f < 100; f++) begin
            bh_dly = int'($urandom_range(1, 6));
            bl_dly = int'($urandom_range(20, 60));
            do_frame(($urandom_range(0, 3) == 0));
            repeat (int'($urandom_range(0, 5))) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("mutual_exclusion", 32'(n_excl_viol), 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("frame_done_count", 32'(n_fd), 32'(n_frames_exp));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ads8528_ctrl.md
# ads8528_ctrl

Synthesizable host-side controller for the ADS8528 8-channel SAR ADC parallel interface. After reset it writes the 32-bit configuration register as two 16-bit words. On each `start` pulse it fires CONVST_A..D simultaneously, tracks BUSY through the conversion, then issues eight RD_N strobes and streams the samples (A0, A1, B0 … D1) to the sound-localization datapath. It sits between the FPGA fabric and the ADC pins; tristating of DB is done at the pad wrapper.

## Interface
- `CONFIG_WORD`, 32'h0000_03FF: value written to CONFIG_REG. Bit 29 (CLKSEL) = 0, so the ADC uses its internal conversion clock.
- `T_WR_LO`, 3: WR_N low width, in clk cycles (≥1).
- `T_WR_HI`, 3: WR_N high time between writes, and CS_N hold, in cycles (≥1).
- `T_CONV_HI`, 4: CONVST_x high width, in cycles (≥1).
- `T_RD_LO`, 4: RD_N low width, in cycles. Data is sampled on the last low cycle.
- `T_RD_HI`, 3: RD_N high time between reads, in cycles (≥1).
- `BUSY_TIMEOUT`, 1024: maximum cycles allowed in either BUSY-wait state.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle conversion request. Sampled only in IDLE; ignored otherwise.
- `busy`  in  1  ADC BUSY pin, asynchronous. Passed through an internal 2-flop synchronizer.
- `db_in`  in  16  DB pin input path.
- `db_out`  out  16  DB drive value.
- `db_oe`  out  1  DB output enable. Asserted only while WR_N is low, or during its setup/hold cycles in CFG states.
- `cs_n`, `wr_n`, `rd_n`  out  1 each  ADC strobes.
- `convst_a`, `convst_b`, `convst_c`, `convst_d`  out  1 each  conversion starts, driven identically.
- `ready`  out  1  high in IDLE only.
- `sample_data`  out  16  captured word.
- `sample_ch`  out  3  index 0..7 = A0, A1, B0, B1, C0, C1, D0, D1.
- `sample_valid`  out  1  one-cycle pulse per word. There is no backpressure.
- `frame_done`  out  1  one-cycle pulse, coincident with the `sample_valid` for index 7.
- `timeout_err`  out  1  one-cycle pulse when a BUSY wait expires.

## Operation
- Reset values:
  - `cs_n`, `wr_n`, `rd_n` = 1.
  - `convst_*` = 0; `db_oe` = 0; `db_out` = 0.
  - `ready`, `sample_valid`, `frame_done`, `timeout_err` = 0.
  - `sample_data` = 0; `sample_ch` = 0.
  - State = CFG_SETUP.
- States and transitions:
  - CFG_SETUP: assert cs_n low and db_oe; load `db_out` = CONFIG_WORD[31:16]. Hold 1 cycle → CFG_WR.
  - CFG_WR: wr_n low for T_WR_LO cycles, then high for T_WR_HI cycles. After word 0, load word 1 (CONFIG_WORD[15:0]) and repeat. After word 1, drop db_oe, raise cs_n → IDLE.
  - IDLE: ready = 1. On `start` → CONV.
  - CONV: convst_* high for T_CONV_HI cycles, then low → WAIT_BH.
  - WAIT_BH: wait for synchronized busy = 1 → WAIT_BL.
  - WAIT_BL: wait for synchronized busy = 0 → READ, with cs_n low.
  - READ: 8 iterations. Each iteration is rd_n low for T_RD_LO cycles, then high for T_RD_HI cycles. On the last low cycle, `db_in` is registered into `sample_data` and `sample_ch` = read index. sample_valid pulses the cycle after capture. After index 7: raise cs_n, pulse frame_done → IDLE.
- Timeouts:
  - WAIT_BH and WAIT_BL share one down-counter, loaded with BUSY_TIMEOUT on state entry.
  - At zero: pulse timeout_err, force convst/cs_n/rd_n inactive, → IDLE. No samples are emitted.
- Read index: 3-bit counter, cleared on entry to READ, never wraps mid-frame. Exactly 8 reads per frame.
- Width-timing counter: sized clog2 of the maximum T_* parameter plus 1. It reloads on every phase change.
- Mutual exclusion: wr_n and rd_n are never low in the same cycle. db_oe is never 1 while rd_n is 0.
- Configuration is written once per reset. A reset asserted mid-frame aborts immediately to reset values; the next frame restarts config.

## Timing
- `start` in IDLE → convst_* high on the next clk edge.
- busy rise is visible to the FSM 2 cycles after the pin changes, via the synchronizer. The same applies to busy fall.
- busy fall (pin) → first rd_n low: 3 cycles (2 sync + 1 state transition).
- Frame length after BUSY low: 8·(T_RD_LO+T_RD_HI) + 3 cycles. That is 59 cycles at defaults.
- Config sequence: 2·(T_WR_LO+T_WR_HI) + 2 cycles after reset release. That is 14 cycles at defaults.
- All outputs are registered; no combinational path from inputs to pins.

## Structure
- `ads8528_pkg`:
  - state enum `ctrl_state_t`.
  - channel index constants CH_A0..CH_D1.
  - CLKSEL bit position (29).
  - default CONFIG_WORD.
- Sub-module `sync_2ff` for the busy input, reusable elsewhere.
- The FSM, timing counter and read counter stay in `ads8528_ctrl`.

## Test plan
- Reset release with default parameters, bench monitoring DB: two WR_N pulses latch 0x0000 then 0x03FF. Each WR_N low lasts 3 cycles. cs_n is low throughout, db_oe is high only around the writes, and ready rises at cycle 14.
- Single `start`, behavioural ADC producing BUSY high after 2 cycles and low after 40: exactly 8 sample_valid pulses with sample_ch 0..7. The data matches the ADC's CH_A0..CH_D1, and frame_done is coincident with ch 7.
- BUSY held low forever after `start`: timeout_err pulses 1024 cycles after entering WAIT_BH, no sample_valid, ready = 1 the next cycle.
- `start` pulsed during READ: ignored. Exactly one frame of 8 samples, then IDLE.
- rst_n asserted during read index 4: all outputs at reset values asynchronously. After release, the config writes repeat and no further samples from the aborted frame appear.
- Continuous assertion over 100 frames: wr_n and rd_n are never low together, and db_oe is never 1 while rd_n is 0.
